deserializer_checker: RTL and testbench

Serial-to-parallel receive stage for the self-test path. It samples the 1-bit MSB-first stream produced by the upstream serializer and hunts for a sync byte to find the byte boundary. It then rebuilds bytes and checks a fixed-length incrementing payload against the expected values. It reports the recovered bytes, lock status, an error count and a final pass/fail verdict.

---
 rtl/self_test_pkg.sv | 20 ++
 rtl/deser_shift.sv | 22 ++
 rtl/deserializer_checker.sv | 167 ++++++++++++++++
 tb/tb_deserializer_checker.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/self_test_pkg.sv
// Shared definitions for the self-test receive path: FSM states, the default
// alignment marker and the payload pattern rule used by both ends of the link.
package self_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam logic [7:0] PAYLOAD_FIRST = 8'h00;

  // Payload is an incrementing byte sequence that wraps modulo 256.
  function automatic logic [7:0] payload_next(input logic [7:0] cur);
    return cur + 8'd1;
  endfunction

endpackage

// File: rtl/deser_shift.sv
// Serial history register: o_win is the eight most recent bits, MSB oldest,
// with the bit currently on i_data in the LSB.
module deser_shift (
  input  logic       t_clk,
  input  logic       i_rst,
  input  logic       i_data,
  output logic [7:0] o_win
);

  // The live bit completes the window, so only seven bits of history are stored.
  logic [6:0] r_sr;

  assign o_win = {r_sr, i_data};

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order of statements.
  always_ff @(posedge t_clk) begin
    if (i_rst) r_sr <= '0;
    else       r_sr <= o_win[6:0];
  end

endmodule

// File: rtl/deserializer_checker.sv
// Receive stage of the self-test path: finds the byte boundary via a sync byte,
// rebuilds payload bytes MSB-first and checks them against an incrementing pattern.
module deserializer_checker
  import self_test_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
  parameter int         TEST_LEN  = 16,
  parameter int         HUNT_MAX  = 64,
  parameter int         ERR_W     = 8
) (
  input  logic             t_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             data_in,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             locked,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int              HT_W      = $clog2(HUNT_MAX);
  localparam logic [HT_W-1:0] HUNT_LAST = HT_W'(HUNT_MAX - 1);
  localparam logic [7:0]      LAST_IDX  = 8'(TEST_LEN - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [7:0]       w_win;
  logic [HT_W-1:0]  r_hunt_tmr;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_expected;
  logic [7:0]       r_payload_cnt;
  logic [7:0]       r_byte_out;
  logic             r_byte_valid;
  logic             r_locked;
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [ERR_W-1:0] r_err_cnt;
  logic [ERR_W-1:0] w_err_nxt;
  logic             w_start_run;
  logic             w_sync_hit;
  logic             w_timeout;
  logic             w_byte_end;
  logic             w_last_byte;

  deser_shift u_shift (
    .t_clk  (t_clk),
    .i_rst  (rst),
    .i_data (data_in),
    .o_win  (w_win)
  );

  always_ff @(posedge t_clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_start_run = 1'b0;
    w_sync_hit  = 1'b0;
    w_timeout   = 1'b0;
    w_byte_end  = 1'b0;
    w_last_byte = 1'b0;
    w_err_nxt   = r_err_cnt;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          w_start_run = 1'b1;
          w_state_nxt = ST_HUNT;
        end
      end
      ST_HUNT: begin
        // A match in the same cycle as the last allowed hunt cycle still locks.
        if (w_win == SYNC_BYTE) begin
          w_sync_hit  = 1'b1;
          w_state_nxt = ST_CHECK;
        end else if (r_hunt_tmr == HUNT_LAST) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_CHECK: begin
        if (r_bit_cnt == 3'd7) begin
          w_byte_end = 1'b1;
          if ((w_win != r_expected) && (r_err_cnt != '1)) begin
            w_err_nxt = r_err_cnt + ERR_W'(1);
          end
          if (r_payload_cnt == LAST_IDX) begin
            w_last_byte = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge t_clk) begin
    if (rst) begin
      r_hunt_tmr    <= '0;
      r_bit_cnt     <= '0;
      r_expected    <= '0;
      r_payload_cnt <= '0;
      r_byte_out    <= '0;
      r_byte_valid  <= 1'b0;
      r_locked      <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_err_cnt     <= '0;
    end else begin
      r_byte_valid <= w_byte_end;
      if (w_start_run) begin
        r_err_cnt     <= '0;
        r_pass        <= 1'b0;
        r_done        <= 1'b0;
        r_locked      <= 1'b0;
        r_payload_cnt <= '0;
        r_hunt_tmr    <= '0;
        r_busy        <= 1'b1;
      end
      if (r_state == ST_HUNT) begin
        r_hunt_tmr <= r_hunt_tmr + HT_W'(1);
        if (w_sync_hit) begin
          r_locked   <= 1'b1;
          r_bit_cnt  <= '0;
          r_expected <= PAYLOAD_FIRST;
        end else if (w_timeout) begin
          r_done   <= 1'b1;
          r_pass   <= 1'b0;
          r_locked <= 1'b0;
          r_busy   <= 1'b0;
        end
      end
      if (r_state == ST_CHECK) begin
        r_bit_cnt <= r_bit_cnt + 3'd1;
        if (w_byte_end) begin
          r_byte_out    <= w_win;
          r_err_cnt     <= w_err_nxt;
          r_expected    <= payload_next(r_expected);
          r_payload_cnt <= r_payload_cnt + 8'd1;
        end
        // The verdict includes the final byte, hence w_err_nxt rather than r_err_cnt.
        if (w_last_byte) begin
          r_done <= 1'b1;
          r_busy <= 1'b0;
          r_pass <= (w_err_nxt == '0);
        end
      end
    end
  end

  assign byte_out   = r_byte_out;
  assign byte_valid = r_byte_valid;
  assign locked     = r_locked;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_deserializer_checker.sv
// Randomised bench for deserializer_checker: a bit-level model predicts lock
// point, recovered bytes, strobe cycles and verdict from the raw stimulus.
module tb_deserializer_checker;

  localparam logic [7:0] SYNC   = 8'hA5;
  localparam int A_TEST_LEN     = 16;
  localparam int A_HUNT         = 64;
  localparam int B_TEST_LEN     = 8;
  localparam int B_HUNT         = 64;
  localparam int B_ERR_W        = 2;

  logic t_clk = 1'b0;
  always #5 t_clk = ~t_clk;

  logic rst, data_in, start_a, start_b, sel;

  logic [7:0]         a_byte_out, b_byte_out;
  logic               a_byte_valid, a_locked, a_busy, a_done, a_pass;
  logic               b_byte_valid, b_locked, b_busy, b_done, b_pass;
  logic [7:0]         a_err_cnt;
  logic [B_ERR_W-1:0] b_err_cnt;

  deserializer_checker #(.SYNC_BYTE(SYNC), .TEST_LEN(A_TEST_LEN), .HUNT_MAX(A_HUNT), .ERR_W(8)) dut_a (
    .t_clk(t_clk), .rst(rst), .start(start_a), .data_in(data_in),
    .byte_out(a_byte_out), .byte_valid(a_byte_valid), .locked(a_locked), .busy(a_busy),
    .done(a_done), .pass(a_pass), .err_cnt(a_err_cnt));

  deserializer_checker #(.SYNC_BYTE(SYNC), .TEST_LEN(B_TEST_LEN), .HUNT_MAX(B_HUNT), .ERR_W(B_ERR_W)) dut_b (
    .t_clk(t_clk), .rst(rst), .start(start_b), .data_in(data_in),
    .byte_out(b_byte_out), .byte_valid(b_byte_valid), .locked(b_locked), .busy(b_busy),
    .done(b_done), .pass(b_pass), .err_cnt(b_err_cnt));

  logic [7:0] ob_byte, ob_err;
  logic       ob_valid, ob_locked, ob_busy, ob_done, ob_pass;

  always_comb begin
    if (sel) begin
      ob_byte = b_byte_out; ob_valid = b_byte_valid; ob_locked = b_locked;
      ob_busy = b_busy; ob_done = b_done; ob_pass = b_pass; ob_err = {6'd0, b_err_cnt};
    end else begin
      ob_byte = a_byte_out; ob_valid = a_byte_valid; ob_locked = a_locked;
      ob_busy = a_busy; ob_done = a_done; ob_pass = a_pass; ob_err = a_err_cnt;
    end
  end

  int n_checks = 0;
  int n_errors = 0;
  bit stim[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) stim.push_back(b[i]);
  endtask

  function automatic bit bit_at(input int j);
    return (j >= 0 && j < stim.size()) ? stim[j] : 1'b0;
  endfunction

  task automatic set_start(input logic v);
    if (sel) start_b = v; else start_a = v;
  endtask

  task automatic tick();
    @(posedge t_clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "/byte_out"},   ob_byte,   0);
    check({name, "/byte_valid"}, ob_valid,  0);
    check({name, "/locked"},     ob_locked, 0);
    check({name, "/busy"},       ob_busy,   0);
    check({name, "/done"},       ob_done,   0);
    check({name, "/pass"},       ob_pass,   0);
    check({name, "/err_cnt"},    ob_err,    0);
  endtask

  // Stream stim[] after a start pulse; cycle c is observed just after the edge sampling stim[c].
  task automatic run(input string name, input int mid_start, input int rst_after);
    int test_len, hunt, err_max, lock_c, exp_done_c, exp_err, got_done, limit;
    logic exp_pass, reset_seen;
    logic [7:0] w, v;
    logic [7:0] exp_val[$];
    int exp_c[$];
    logic [7:0] obs_val[$];
    int obs_c[$];

    test_len = sel ? B_TEST_LEN : A_TEST_LEN;
    hunt     = sel ? B_HUNT : A_HUNT;
    err_max  = sel ? (1 << B_ERR_W) - 1 : 255;

    lock_c = -1;
    for (int c = 0; c < hunt; c++) begin
      w = 8'd0;
      for (int j = c - 7; j <= c; j++) w = {w[6:0], bit_at(j)};
      if (w == SYNC) begin
        lock_c = c;
        break;
      end
    end
    exp_err = 0;
    if (lock_c < 0) begin
      exp_done_c = hunt - 1;
    end else begin
      for (int k = 0; k < test_len; k++) begin
        v = 8'd0;
        for (int b = 0; b < 8; b++) v = {v[6:0], bit_at(lock_c + 1 + 8 * k + b)};
        exp_val.push_back(v);
        exp_c.push_back(lock_c + 8 * (k + 1));
        if (v != 8'(k % 256) && exp_err < err_max) exp_err++;
      end
      exp_done_c = lock_c + 8 * test_len;
    end
    exp_pass = (lock_c >= 0) && (exp_err == 0);

    data_in = 1'b0;
    set_start(1'b0);
    repeat (8) tick();
    set_start(1'b1);
    tick();
    set_start(1'b0);
    check({name, "/busy_rise"}, ob_busy, 1);
    check({name, "/done_clear"}, ob_done, 0);

    got_done   = -1;
    reset_seen = 1'b0;
    limit      = exp_done_c + 20;
    for (int c = 0; c <= limit; c++) begin
      data_in = bit_at(c);
      set_start(c == mid_start);
      tick();
      if (lock_c > 0 && c == lock_c - 1) check({name, "/locked_pre"}, ob_locked, 0);
      if (c == lock_c) check({name, "/locked_at"}, ob_locked, 1);
      if (ob_valid) begin
        obs_val.push_back(ob_byte);
        obs_c.push_back(c);
      end
      if (rst_after > 0 && obs_val.size() == rst_after) begin
        set_start(1'b0);
        rst = 1'b1;
        data_in = 1'b0;
        tick();
        rst = 1'b0;
        check_all_zero({name, "/after_rst"});
        reset_seen = 1'b1;
        break;
      end
      if (ob_done) begin
        got_done = c;
        break;
      end
    end
    set_start(1'b0);

    if (rst_after > 0) begin
      check({name, "/rst_reached"}, reset_seen, 1);
      return;
    end

    check({name, "/done_cycle"}, got_done, exp_done_c);
    check({name, "/pass"},       ob_pass,   exp_pass);
    check({name, "/err_cnt"},    ob_err,    exp_err);
    check({name, "/locked_end"}, ob_locked, lock_c >= 0);
    check({name, "/busy_fall"},  ob_busy,   0);
    check({name, "/n_bytes"},    obs_val.size(), exp_val.size());
    for (int i = 0; i < obs_val.size() && i < exp_val.size(); i++) begin
      check($sformatf("%s/byte%0d", name, i),  obs_val[i], exp_val[i]);
      check($sformatf("%s/cycle%0d", name, i), obs_c[i],   exp_c[i]);
    end

    repeat (3) begin
      data_in = 1'($urandom_range(0, 1));
      tick();
    end
    check({name, "/hold_done"}, ob_done, 1);
    check({name, "/hold_err"},  ob_err,  exp_err);
    check({name, "/hold_pass"}, ob_pass, exp_pass);
  endtask

  initial begin
    rst = 1'b1; data_in = 1'b0; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;

    stim.delete(); push_byte(SYNC);
    for (int k = 0; k < 16; k++) push_byte(8'(k));
    run("clean", -1, 0);

    stim.delete();
    for (int i = 0; i < 3; i++) stim.push_back(1'($urandom_range(0, 1)));
    push_byte(SYNC);
    for (int k = 0; k < 16; k++) push_byte(8'(k));
    run("misalign", -1, 0);

    stim.delete(); push_byte(SYNC);
    for (int k = 0; k < 16; k++) push_byte(k == 5 ? 8'h45 : 8'(k));
    run("corrupt", -1, 0);

    stim.delete();
    run("timeout", -1, 0);

    stim.delete(); push_byte(SYNC);
    for (int k = 0; k < 16; k++) push_byte(8'(k));
    run("mid_start", 40, 0);
    run("mid_rst", -1, 4);
    run("after_rst", -1, 0);

    sel = 1'b1;
    stim.delete(); push_byte(SYNC);
    for (int k = 0; k < 8; k++) push_byte(8'hFF);
    run("saturate", -1, 0);
    sel = 1'b0;

    for (int r = 0; r < 6; r++) begin
      stim.delete();
      for (int i = 0; i < int'($urandom_range(0, 12)); i++) stim.push_back(1'($urandom_range(0, 1)));
      push_byte(SYNC);
      for (int k = 0; k < 16; k++)
        push_byte(($urandom_range(0, 3) == 0) ? 8'(k) ^ 8'($urandom_range(1, 255)) : 8'(k));
      run($sformatf("rand%0d", r), -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
